// File: rtl/stock_result_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : stock_result_arbiter
// Purpose  : N-channel result collector. Each channel's one-cycle result
//            strobe is captured into a holding register. A round-robin arbiter
//            moves pending results into a tagged show-ahead FIFO that drives
//            a valid/ready output stream.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            in_valid/in_data  - per-channel strobes and packed data slices
//            out_valid/out_data/out_ch/out_ready - tagged output stream
//            overrun/clear_ovr - sticky per-channel overwrite flags and clear
//            fifo_count        - current output FIFO occupancy
// Revision : 1.0 - initial release
// ============================================================================
module stock_result_arbiter #(
    parameter int N_CH       = 11,
    parameter int DATA_W     = 40,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_W       = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_CH-1:0]               in_valid,
    input  logic [N_CH*DATA_W-1:0]        in_data,
    output logic                          out_valid,
    output logic [DATA_W-1:0]             out_data,
    output logic [ID_W-1:0]               out_ch,
    input  logic                          out_ready,
    output logic [N_CH-1:0]               overrun,
    input  logic                          clear_ovr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [ID_W-1:0]  c_last_ch = ID_W'(N_CH - 1);
    localparam logic [CNT_W-1:0] c_depth   = CNT_W'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [N_CH-1:0]   pend_q,       pend_d;
    logic [N_CH-1:0]   ovr_q,        ovr_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [PTR_W-1:0]  wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,     rd_ptr_d;
    logic [CNT_W-1:0]  count_q,      count_d;

    // Datapath storage; never observable before being written, so unreset.
    logic [DATA_W-1:0] hold_q     [N_CH];
    logic [DATA_W-1:0] hold_d     [N_CH];
    logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data_d [FIFO_DEPTH];
    logic [ID_W-1:0]   mem_ch_q   [FIFO_DEPTH];
    logic [ID_W-1:0]   mem_ch_d   [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Arbitration / handshake wires
    // ------------------------------------------------------------------
    logic [ID_W-1:0]   search_start;
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic              pop;
    logic              can_push;
    logic              push;
    logic [N_CH-1:0]   grant_hit;
    logic [DATA_W-1:0] push_data;

    assign out_valid  = (count_q != '0);
    assign pop        = out_valid & out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign can_push   = (count_q != c_depth) | pop;
    assign push       = grant_found & can_push;
    assign overrun    = ovr_q;
    assign fifo_count = count_q;

    // Head is gated so the stream reads zero whenever the FIFO is empty.
    assign out_data = out_valid ? mem_data_q[rd_ptr_q] : '0;
    assign out_ch   = out_valid ? mem_ch_q[rd_ptr_q]   : '0;

    // Round-robin search over registered pend only. First pass takes the
    // lowest pending channel at or above the start point; the second pass
    // handles the wrap by taking the lowest pending channel overall.
    always_comb begin : p_arbiter
        search_start = (last_grant_q == c_last_ch) ? '0 : last_grant_q + ID_W'(1);
        grant_found  = 1'b0;
        grant_idx    = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (!grant_found && pend_q[k] && (ID_W'(k) >= search_start)) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(k);
            end
        end
        for (int k = 0; k < N_CH; k++) begin
            if (!grant_found && pend_q[k]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(k);
            end
        end
    end

    always_comb begin : p_grant_decode
        grant_hit = '0;
        push_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (push && (grant_idx == ID_W'(k))) begin
                grant_hit[k] = 1'b1;
                push_data    = hold_q[k];
            end
        end
    end

    // Capture, pending and overrun update. A grant and a capture on the same
    // channel push the old data while the new data stays pending.
    always_comb begin : p_channel_next
        pend_d = pend_q;
        ovr_d  = clear_ovr ? '0 : ovr_q;
        hold_d = hold_q;
        for (int k = 0; k < N_CH; k++) begin
            if (grant_hit[k]) begin
                pend_d[k] = 1'b0;
            end
            if (in_valid[k]) begin
                hold_d[k] = in_data[k*DATA_W +: DATA_W];
                pend_d[k] = 1'b1;
                // An overrun event overrides a same-cycle clear.
                if (pend_q[k] && !grant_hit[k]) begin
                    ovr_d[k] = 1'b1;
                end
            end
        end
        last_grant_d = push ? grant_idx : last_grant_q;
    end

    always_comb begin : p_fifo_next
        mem_data_d = mem_data_q;
        mem_ch_d   = mem_ch_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            mem_data_d[wr_ptr_q] = push_data;
            mem_ch_d[wr_ptr_q]   = grant_idx;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin : p_ctrl_regs
        if (!rst_n) begin
            pend_q       <= '0;
            ovr_q        <= '0;
            last_grant_q <= c_last_ch;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            pend_q       <= pend_d;
            ovr_q        <= ovr_d;
            last_grant_q <= last_grant_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge clk) begin : p_data_regs
        hold_q     <= hold_d;
        mem_data_q <= mem_data_d;
        mem_ch_q   <= mem_ch_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_stock_result_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_stock_result_arbiter
// Purpose  : Self-checking bench for stock_result_arbiter. Expected stream
//            entries are queued when stimulus is driven and compared as the
//            DUT hands them off; status outputs are checked at directed points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stock_result_arbiter;

    localparam int N_CH       = 11;
    localparam int DATA_W     = 40;
    localparam int FIFO_DEPTH = 4;
    localparam int ID_W       = 4;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

    typedef logic [ID_W+DATA_W-1:0] entry_t;

    logic                   clk;
    logic                   rst_n;
    logic [N_CH-1:0]        in_valid;
    logic [N_CH*DATA_W-1:0] in_data;
    logic                   out_valid;
    logic [DATA_W-1:0]      out_data;
    logic [ID_W-1:0]        out_ch;
    logic                   out_ready;
    logic [N_CH-1:0]        overrun;
    logic                   clear_ovr;
    logic [CNT_W-1:0]       fifo_count;

    entry_t sb[$];
    int     checks = 0;
    int     errors = 0;

    stock_result_arbiter #(
        .N_CH(N_CH), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready), .overrun(overrun), .clear_ovr(clear_ovr),
        .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic entry_t ent(input int ch, input logic [DATA_W-1:0] d);
        return {ID_W'(ch), d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [N_CH-1:0] mask, input logic [N_CH*DATA_W-1:0] bus);
        in_valid = mask;
        in_data  = bus;
        tick();
        in_valid = '0;
        in_data  = '0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        clear_ovr = 1'b0;
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_empty(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard: every accepted output entry must match the next expected one.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("output_with_empty_scoreboard", 64'(sb.size()), 64'd1);
            end else begin
                entry_t e;
                e = sb.pop_front();
                check("out_entry", 64'({out_ch, out_data}), 64'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N_CH*DATA_W-1:0] bus;
        logic [N_CH-1:0]        mask;

        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        clear_ovr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_count",     64'(fifo_count), 64'd0);
        check("reset_overrun",   64'(overrun), 64'd0);
        check("reset_out_data",  64'(out_data), 64'd0);
        check("reset_out_ch",    64'(out_ch), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single channel: 2-cycle strobe-to-output latency.
        out_ready = 1'b1;
        bus = '0;
        bus[3*DATA_W +: DATA_W] = 40'h00_0000_1234;
        sb.push_back(ent(3, 40'h00_0000_1234));
        strobe(11'b000_0000_1000, bus);
        @(negedge clk);
        check("t1_valid_after_capture", 64'(out_valid), 64'd0);
        tick();
        @(negedge clk);
        check("t1_valid_after_push", 64'(out_valid), 64'd1);
        check("t1_out_ch", 64'(out_ch), 64'd3);
        tick();
        @(negedge clk);
        check("t1_count_back_to_zero", 64'(fifo_count), 64'd0);

        // All channels at once: 11 outputs on consecutive cycles, in order.
        do_reset();
        out_ready = 1'b1;
        bus = '0;
        for (int k = 0; k < N_CH; k++) begin
            bus[k*DATA_W +: DATA_W] = DATA_W'(k);
            sb.push_back(ent(k, DATA_W'(k)));
        end
        strobe('1, bus);
        tick();
        for (int i = 0; i < N_CH; i++) begin
            @(negedge clk);
            check("t2_stream_valid", 64'(out_valid), 64'd1);
            tick();
        end
        @(negedge clk);
        check("t2_count", 64'(fifo_count), 64'd0);
        check("t2_overrun", 64'(overrun), 64'd0);

        // Round-robin fairness: channels 2 and 5 strobe every cycle.
        do_reset();
        out_ready = 1'b1;
        mask = '0;
        mask[2] = 1'b1;
        mask[5] = 1'b1;
        sb.push_back(ent(2, 40'h201));
        sb.push_back(ent(5, 40'h502));
        sb.push_back(ent(2, 40'h203));
        sb.push_back(ent(5, 40'h504));
        sb.push_back(ent(2, 40'h205));
        sb.push_back(ent(5, 40'h506));
        sb.push_back(ent(2, 40'h206));
        for (int n = 1; n <= 6; n++) begin
            bus = '0;
            bus[2*DATA_W +: DATA_W] = 40'h200 + DATA_W'(n);
            bus[5*DATA_W +: DATA_W] = 40'h500 + DATA_W'(n);
            in_valid = mask;
            in_data  = bus;
            tick();
        end
        in_valid = '0;
        in_data  = '0;
        wait_empty(20);
        @(negedge clk);
        check("t3_overrun_2_5", 64'(overrun), 64'(mask));
        clear_ovr = 1'b1;
        tick();
        clear_ovr = 1'b0;
        @(negedge clk);
        check("t3_overrun_cleared", 64'(overrun), 64'd0);

        // Backpressure: six strobes, four fit, two stay pending.
        do_reset();
        out_ready = 1'b0;
        mask = '0;
        bus  = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (k == 1 || k == 3 || k == 4 || k == 6 || k == 8 || k == 9) begin
                mask[k] = 1'b1;
                bus[k*DATA_W +: DATA_W] = 40'hC0_0000_0000 + DATA_W'(k * 17);
                sb.push_back(ent(k, 40'hC0_0000_0000 + DATA_W'(k * 17)));
            end
        end
        strobe(mask, bus);
        repeat (5) tick();
        @(negedge clk);
        check("t4_count_full", 64'(fifo_count), 64'd4);
        check("t4_head_ch", 64'(out_ch), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("t4_head_valid_stable", 64'(out_valid), 64'd1);
            check("t4_head_data_stable", 64'(out_data), 64'h00C0_0000_0011);
        end
        out_ready = 1'b1;
        wait_empty(20);
        @(negedge clk);
        check("t4_count_drained", 64'(fifo_count), 64'd0);

        // Overrun and clear with a full FIFO; newest data wins.
        do_reset();
        out_ready = 1'b0;
        mask = '0;
        bus  = '0;
        for (int k = 0; k < 5; k++) begin
            mask[k] = 1'b1;
            bus[k*DATA_W +: DATA_W] = 40'h50 + DATA_W'(k);
            sb.push_back(ent(k, 40'h50 + DATA_W'(k)));
        end
        strobe(mask, bus);
        repeat (4) tick();
        @(negedge clk);
        check("t5_count_full", 64'(fifo_count), 64'd4);
        bus = '0;
        bus[7*DATA_W +: DATA_W] = 40'hAA;
        strobe(11'b000_1000_0000, bus);
        @(negedge clk);
        check("t5_no_overrun_first", 64'(overrun), 64'd0);
        bus[7*DATA_W +: DATA_W] = 40'hBB;
        strobe(11'b000_1000_0000, bus);
        @(negedge clk);
        check("t5_overrun_7", 64'(overrun), 64'h80);
        // Overrun event and clear in the same cycle: event keeps the bit set.
        bus[7*DATA_W +: DATA_W] = 40'hCC;
        clear_ovr = 1'b1;
        strobe(11'b000_1000_0000, bus);
        clear_ovr = 1'b0;
        @(negedge clk);
        check("t5_clear_vs_event", 64'(overrun), 64'h80);
        clear_ovr = 1'b1;
        tick();
        clear_ovr = 1'b0;
        @(negedge clk);
        check("t5_clear_ovr", 64'(overrun), 64'd0);
        sb.push_back(ent(7, 40'hCC));
        out_ready = 1'b1;
        wait_empty(20);

        // Reset mid-operation: three queued, two pending, all discarded.
        do_reset();
        out_ready = 1'b0;
        mask = '0;
        bus  = '0;
        for (int k = 0; k < 5; k++) begin
            mask[k] = 1'b1;
            bus[k*DATA_W +: DATA_W] = 40'h60 + DATA_W'(k);
        end
        strobe(mask, bus);
        repeat (3) tick();
        @(negedge clk);
        check("t6_count_before_reset", 64'(fifo_count), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_out_valid", 64'(out_valid), 64'd0);
        check("t6_async_count", 64'(fifo_count), 64'd0);
        check("t6_async_out_data", 64'(out_data), 64'd0);
        check("t6_async_out_ch", 64'(out_ch), 64'd0);
        sb.delete();
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_no_ghost_output", 64'(out_valid), 64'd0);
            tick();
        end
        bus = '0;
        bus[0*DATA_W +: DATA_W]  = 40'h70;
        bus[10*DATA_W +: DATA_W] = 40'h7A;
        sb.push_back(ent(0, 40'h70));
        sb.push_back(ent(10, 40'h7A));
        strobe(11'b100_0000_0001, bus);
        wait_empty(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
